// File: rtl/phase_sequencer.sv
// N-phase instruction sequencer with stall, early termination, halt/resume and a retired-instruction counter.
// Optional single-step from HALTED is compiled in with PHASE_SEQ_STEP_EN.
module phase_sequencer #(
    parameter int NUM_PHASES = 2,
    localparam int PW        = $clog2(NUM_PHASES),
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  early_end,
    input  logic                  halt_req,
    input  logic                  resume,
    input  logic                  step,
    output logic [PW-1:0]         phase,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  instr_done,
    output logic                  halted,
    output logic [CNT_W-1:0]      instr_count
);

`ifdef PHASE_SEQ_STEP_EN
    typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP} state_t;
`else
    typedef enum logic [1:0] {S_RUN, S_HALTED} state_t;
    logic unused_step;
    assign unused_step = step;
`endif

    localparam logic [PW-1:0]         LAST_PHASE = PW'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] ONEHOT0    = NUM_PHASES'(1);

    state_t                  state_q, state_n;
    logic [PW-1:0]           phase_q, phase_n;
    logic [NUM_PHASES-1:0]   onehot_q;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic                    pend_q, pend_n;
    logic                    active, boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RUN;
            phase_q  <= '0;
            onehot_q <= ONEHOT0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            phase_q  <= phase_n;
            onehot_q <= ONEHOT0 << phase_n;
            cnt_q    <= cnt_n;
            pend_q   <= pend_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        phase_n  = phase_q;
        cnt_n    = cnt_q;
        pend_n   = pend_q | halt_req;
`ifdef PHASE_SEQ_STEP_EN
        active   = (state_q == S_RUN) || (state_q == S_STEP);
`else
        active   = (state_q == S_RUN);
`endif
        boundary   = (phase_q == LAST_PHASE) || early_end;
        instr_done = active && !stall && boundary;

        if (active && !stall) begin
            if (boundary) begin
                phase_n = '0;
                cnt_n   = cnt_q + CNT_W'(1);
                // A pulse arriving on the boundary cycle itself still halts here.
                if (pend_q || halt_req) begin
                    state_n = S_HALTED;
                    pend_n  = 1'b0;
                end
            end else begin
                phase_n = phase_q + PW'(1);
            end
        end

`ifdef PHASE_SEQ_STEP_EN
        if (state_q == S_STEP && state_n == S_STEP) begin
            if (resume)
                state_n = S_RUN;
            else if (instr_done)
                state_n = S_HALTED;
        end
`endif

        if (state_q == S_HALTED) begin
            // Halt is already satisfied; a request seen while halted is not remembered.
            phase_n = '0;
            pend_n  = 1'b0;
            if (resume && !halt_req)
                state_n = S_RUN;
`ifdef PHASE_SEQ_STEP_EN
            else if (step && !resume)
                state_n = S_STEP;
`endif
        end
    end

    assign phase        = phase_q;
    assign phase_onehot = onehot_q;
    assign halted       = (state_q == S_HALTED);
    assign instr_count  = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a 2-phase and a 4-phase instance share clock and reset.
module tb_phase_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zero = 1'b0;
    logic       stall4 = 1'b0, ee4 = 1'b0, hr4 = 1'b0, res4 = 1'b0, step4 = 1'b0;

    logic [0:0] p2;
    logic [1:0] oh2;
    logic       done2, h2;
    logic [7:0] cnt2;
    logic [1:0] p4;
    logic [3:0] oh4;
    logic       done4, h4;
    logic [7:0] cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phase_sequencer #(.NUM_PHASES(2), .CNT_W(8)) dut2 (
        .clk(clk), .reset(rst), .stall(zero), .early_end(zero), .halt_req(zero),
        .resume(zero), .step(zero), .phase(p2), .phase_onehot(oh2),
        .instr_done(done2), .halted(h2), .instr_count(cnt2)
    );

    phase_sequencer #(.NUM_PHASES(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset(rst), .stall(stall4), .early_end(ee4), .halt_req(hr4),
        .resume(res4), .step(step4), .phase(p4), .phase_onehot(oh4),
        .instr_done(done4), .halted(h4), .instr_count(cnt4)
    );

    // Leaves time at a negedge just after reset release, all dut4 inputs low.
    task automatic do_reset();
        @(negedge clk);
        stall4 = 0; ee4 = 0; hr4 = 0; res4 = 0; step4 = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({p2, oh2, h2, cnt2} !== {1'b0, 2'b01, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_dut2 got p=%0d oh=%b h=%b cnt=%0d want p=0 oh=01 h=0 cnt=0", p2, oh2, h2, cnt2);
        end
        checks++;
        if ({p4, oh4, h4, cnt4} !== {2'd0, 4'b0001, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_dut4 got p=%0d oh=%b h=%b cnt=%0d want p=0 oh=0001 h=0 cnt=0", p4, oh4, h4, cnt4);
        end
    endtask

    task automatic test_two_phase();
        logic [0:0] exp_p;
        logic [7:0] exp_c;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_p = 1'(i % 2);
            exp_c = 8'(i / 2);
            checks++;
            if ({p2, oh2, cnt2} !== {exp_p, 2'b01 << exp_p, exp_c}) begin
                failures++;
                $display("FAIL two_phase[%0d] got p=%0d oh=%b cnt=%0d want p=%0d cnt=%0d", i, p2, oh2, cnt2, exp_p, exp_c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_early_end();
        do_reset();
        @(negedge clk);
        ee4 = 1;
        #1;
        checks++;
        if ({p4, done4} !== {2'd1, 1'b1}) begin
            failures++;
            $display("FAIL early_end_done got p=%0d done=%b want p=1 done=1", p4, done4);
        end
        @(negedge clk);
        ee4 = 0;
        #1;
        checks++;
        if ({p4, oh4, cnt4, done4} !== {2'd0, 4'b0001, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL early_end_after got p=%0d oh=%b cnt=%0d done=%b want p=0 oh=0001 cnt=1 done=0", p4, oh4, cnt4, done4);
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) @(negedge clk);
        stall4 = 1; ee4 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({p4, cnt4, done4} !== {2'd2, 8'd0, 1'b0}) begin
                failures++;
                $display("FAIL stall[%0d] got p=%0d cnt=%0d done=%b want p=2 cnt=0 done=0", i, p4, cnt4, done4);
            end
            @(negedge clk);
        end
        stall4 = 0; ee4 = 0;
        #1;
        checks++;
        if (p4 !== 2'd2) begin
            failures++;
            $display("FAIL stall_release got p=%0d want 2", p4);
        end
        @(negedge clk);
        checks++;
        if ({p4, oh4} !== {2'd3, 4'b1000}) begin
            failures++;
            $display("FAIL stall_p3 got p=%0d oh=%b want p=3 oh=1000", p4, oh4);
        end
        @(negedge clk);
        checks++;
        if ({p4, cnt4} !== {2'd0, 8'd1}) begin
            failures++;
            $display("FAIL stall_wrap got p=%0d cnt=%0d want p=0 cnt=1", p4, cnt4);
        end
    endtask

    task automatic test_halt_resume();
        do_reset();
        @(negedge clk);
        hr4 = 1;
        @(negedge clk);
        hr4 = 0;
        #1;
        checks++;
        if ({p4, h4} !== {2'd2, 1'b0}) begin
            failures++;
            $display("FAIL halt_p2 got p=%0d h=%b want p=2 h=0", p4, h4);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({p4, h4, done4} !== {2'd3, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL halt_p3 got p=%0d h=%b done=%b want p=3 h=0 done=1", p4, h4, done4);
        end
        @(negedge clk);
        stall4 = 1; ee4 = 1;
        #1;
        checks++;
        if ({p4, oh4, h4, cnt4, done4} !== {2'd0, 4'b0001, 1'b1, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL halted got p=%0d oh=%b h=%b cnt=%0d done=%b want p=0 oh=0001 h=1 cnt=1 done=0", p4, oh4, h4, cnt4, done4);
        end
        @(negedge clk);
        stall4 = 0; ee4 = 0;
        res4 = 1; hr4 = 1;
        @(negedge clk);
        checks++;
        if ({p4, h4, cnt4} !== {2'd0, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL halt_priority got p=%0d h=%b cnt=%0d want p=0 h=1 cnt=1", p4, h4, cnt4);
        end
        hr4 = 0;
        @(negedge clk);
        res4 = 0;
        checks++;
        if ({p4, h4} !== {2'd0, 1'b0}) begin
            failures++;
            $display("FAIL resume got p=%0d h=%b want p=0 h=0", p4, h4);
        end
        @(negedge clk);
        checks++;
        if ({p4, h4, cnt4} !== {2'd1, 1'b0, 8'd1}) begin
            failures++;
            $display("FAIL resume_adv got p=%0d h=%b cnt=%0d want p=1 h=0 cnt=1", p4, h4, cnt4);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        ee4 = 1;
        repeat (255) @(negedge clk);
        checks++;
        if ({p4, cnt4} !== {2'd0, 8'd255}) begin
            failures++;
            $display("FAIL count_255 got p=%0d cnt=%0d want p=0 cnt=255", p4, cnt4);
        end
        @(negedge clk);
        ee4 = 0;
        checks++;
        if ({p4, cnt4} !== {2'd0, 8'd0}) begin
            failures++;
            $display("FAIL count_wrap got p=%0d cnt=%0d want p=0 cnt=0", p4, cnt4);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (p4 !== 2'd2) begin
            failures++;
            $display("FAIL async_pre got p=%0d want 2", p4);
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if ({p4, oh4, cnt4} !== {2'd0, 4'b0001, 8'd0}) begin
            failures++;
            $display("FAIL async_reset got p=%0d oh=%b cnt=%0d want p=0 oh=0001 cnt=0", p4, oh4, cnt4);
        end
        @(negedge clk);
        rst = 0;
    endtask

`ifdef PHASE_SEQ_STEP_EN
    task automatic test_step();
        do_reset();
        hr4 = 1;
        @(negedge clk);
        hr4 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({p4, h4, cnt4} !== {2'd0, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL step_pre got p=%0d h=%b cnt=%0d want p=0 h=1 cnt=1", p4, h4, cnt4);
        end
        step4 = 1;
        @(negedge clk);
        step4 = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({p4, h4, cnt4} !== {2'(i), 1'b0, 8'd1}) begin
                failures++;
                $display("FAIL step_phase[%0d] got p=%0d h=%b cnt=%0d want p=%0d h=0 cnt=1", i, p4, h4, cnt4, i);
            end
            @(negedge clk);
        end
        checks++;
        if ({p4, h4, cnt4} !== {2'd0, 1'b1, 8'd2}) begin
            failures++;
            $display("FAIL step_done got p=%0d h=%b cnt=%0d want p=0 h=1 cnt=2", p4, h4, cnt4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_phase();
        test_early_end();
        test_stall();
        test_halt_resume();
        test_count_wrap();
        test_async_reset();
`ifdef PHASE_SEQ_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
